serial_to_parallel_8: RTL and testbench

- Bit-serial to parallel deserializer. It collects WIDTH single-bit samples and emits one WIDTH-bit word.
- It does the opposite job of the team's 8-to-1 OR reduction path. Instead of collapsing a byte to a bit, it builds a byte from bits.
- It also supplies a registered "any bit set" flag on the output word, so downstream logic does not need a separate OR-reduction stage.
- It sits between a serial link front-end (valid/ready bit stream) and byte-wide datapath logic (valid/ready word stream).

---
 rtl/serial_to_parallel_8.sv | 124 ++++++++++++
 tb/tb_serial_to_parallel_8.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_8.sv
// serial_to_parallel_8
//
// Bit-serial to parallel deserializer. Collects WIDTH single-bit samples from
// a valid/ready bit stream and presents them as one WIDTH-bit word on a
// valid/ready word stream. A registered "any bit set" flag travels with each
// word, so downstream logic does not need a separate OR-reduction stage.
//
// Parameters:
//   WIDTH      word width in bits, 2..32
//   MSB_FIRST  1: first received bit lands in pout_data[WIDTH-1]
//              0: first received bit lands in pout_data[0]
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   rst_n         synchronous, active-low reset
//   sin_valid     a serial bit is offered this cycle
//   sin_data      the serial bit
//   sin_ready     block can accept a bit this cycle
//   pout_valid    pout_data holds a complete word
//   pout_data     assembled word
//   pout_nonzero  registered OR of pout_data, updated together with it
//   pout_ready    consumer accepts the word this cycle
//
// Storage is one output word plus one completed word parked in the shift
// register (FULL state), so the bit stream stalls only when both are occupied.

module serial_to_parallel_8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic             pout_valid,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_nonzero,
  input  logic             pout_ready
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  // COLLECT: assembling bits in sh. FULL: sh holds a finished word waiting
  // for the output register to drain.
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] FULL    = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             last_bit;
  logic             out_free;

  // Gating with rst_n keeps the upstream from seeing a handshake that the
  // reset branch below would throw away.
  assign sin_ready = (state == COLLECT) && rst_n;
  assign accept    = sin_valid && sin_ready;
  assign last_bit  = (cnt == CNT_LAST);
  // The output register can take a new word if it is empty or draining now.
  assign out_free  = !pout_valid || pout_ready;

  // NOTE: every combinational output gets a value on every path (default
  // first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted = sh;
    if (MSB_FIRST) shifted = {sh[WIDTH-2:0], sin_data};
    else           shifted = {sin_data, sh[WIDTH-1:1]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shift register is reset too, so a partial word from before
      // reset can never leak into a later word.
      state        <= COLLECT;
      cnt          <= '0;
      sh           <= '0;
      pout_valid   <= 1'b0;
      pout_data    <= '0;
      pout_nonzero <= 1'b0;
    end else begin
      // A transfer empties the output register unless something refills it
      // below in the same cycle.
      if (pout_valid && pout_ready) pout_valid <= 1'b0;

      case (state)
        COLLECT: begin
          if (accept) begin
            sh <= shifted;
            if (last_bit) begin
              cnt <= '0;
              if (out_free) begin
                pout_data    <= shifted;
                pout_nonzero <= |shifted;
                pout_valid   <= 1'b1;
              end else begin
                state <= FULL;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          // pout_valid is always 1 here; the parked word replaces the one
          // being transferred, so the output never bubbles.
          if (pout_ready) begin
            pout_data    <= sh;
            pout_nonzero <= |sh;
            pout_valid   <= 1'b1;
            state        <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_8.sv
// Testbench for serial_to_parallel_8. Two instances share the stimulus: one
// MSB-first, one LSB-first. A queue-based model of the word storage is
// compared against both on every falling edge; directed checks pin the
// model with hand-computed literals.

module tb_serial_to_parallel_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin_valid;
  logic       sin_data;
  logic       pout_ready;

  logic       sin_ready_m, pout_valid_m, pout_nonzero_m;
  logic [7:0] pout_data_m;
  logic       sin_ready_l, pout_valid_l, pout_nonzero_l;
  logic [7:0] pout_data_l;

  int tests  = 0;
  int failed = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  serial_to_parallel_8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready_m),
    .pout_valid(pout_valid_m), .pout_data(pout_data_m),
    .pout_nonzero(pout_nonzero_m), .pout_ready(pout_ready)
  );

  serial_to_parallel_8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready_l),
    .pout_valid(pout_valid_l), .pout_data(pout_data_l),
    .pout_nonzero(pout_nonzero_l), .pout_ready(pout_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words are stored in arrival order: bit i is the i-th received bit.
  // At most two words can be held (output register + parked word).
  logic [7:0] words[$];
  logic [7:0] acc;
  int         nbits;
  logic [7:0] last_word;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      words.delete();
      acc       = '0;
      nbits     = 0;
      last_word = '0;
    end else begin
      int  held;
      held = words.size();
      if (held > 0 && pout_ready) last_word = words.pop_front();
      if (sin_valid && held < 2) begin
        acc[nbits] = sin_data;
        nbits++;
        if (nbits == 8) begin
          words.push_back(acc);
          acc   = '0;
          nbits = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic       m_valid;
      logic       m_ready;
      logic [7:0] m_word;
      m_valid = (words.size() > 0);
      m_ready = rst_n && (words.size() < 2);
      m_word  = m_valid ? words[0] : last_word;
      check("sin_ready msb",    32'(sin_ready_m),    32'(m_ready));
      check("sin_ready lsb",    32'(sin_ready_l),    32'(m_ready));
      check("pout_valid msb",   32'(pout_valid_m),   32'(m_valid));
      check("pout_valid lsb",   32'(pout_valid_l),   32'(m_valid));
      check("pout_data msb",    32'(pout_data_m),    32'(rev8(m_word)));
      check("pout_data lsb",    32'(pout_data_l),    32'(m_word));
      check("pout_nonzero msb", 32'(pout_nonzero_m), 32'(|m_word));
      check("pout_nonzero lsb", 32'(pout_nonzero_l), 32'(|m_word));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after a rising edge; after tick() returns,
  // outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d);
    sin_valid = v;
    sin_data  = d;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) drive(1'b1, b[i]);
  endtask

  initial begin
    logic [7:0] stream [3];
    int         pulses;

    rst_n      = 1'b0;
    sin_valid  = 1'b0;
    sin_data   = 1'b0;
    pout_ready = 1'b0;
    tick();
    started = 1'b1;
    tick();
    check("reset valid",   32'(pout_valid_m),   32'd0);
    check("reset data",    32'(pout_data_m),    32'd0);
    check("reset nonzero", 32'(pout_nonzero_m), 32'd0);
    check("reset ready",   32'(sin_ready_m),    32'd0);
    rst_n = 1'b1;
    #1;
    check("ready after reset", 32'(sin_ready_m), 32'd1);

    // Basic word 0xA5
    pout_ready = 1'b1;
    send_byte(8'hA5);
    check("basic valid",   32'(pout_valid_m),   32'd1);
    check("basic data",    32'(pout_data_m),    32'hA5);
    check("basic nonzero", 32'(pout_nonzero_m), 32'd1);
    drive(1'b0, 1'b0);
    check("basic one-cycle valid", 32'(pout_valid_m), 32'd0);

    // Bit order: 1,1,0,0,0,0,0,0
    send_byte(8'hC0);
    check("order msb", 32'(pout_data_m), 32'hC0);
    check("order lsb", 32'(pout_data_l), 32'h03);
    drive(1'b0, 1'b0);

    // Zero word with gaps; sin_data=1 during gaps must be ignored
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      if (i < 7) begin
        drive(1'b0, 1'b1);
        check("gap no early word", 32'(pout_valid_m), 32'd0);
      end
    end
    check("zero valid",   32'(pout_valid_m),   32'd1);
    check("zero data",    32'(pout_data_m),    32'h00);
    check("zero nonzero", 32'(pout_nonzero_m), 32'd0);
    drive(1'b0, 1'b0);

    // Back-pressure: 0xFF then 0x01 with pout_ready low
    pout_ready = 1'b0;
    send_byte(8'hFF);
    check("bp first word", 32'(pout_data_m), 32'hFF);
    send_byte(8'h01);
    check("bp full ready", 32'(sin_ready_m), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    check("bp still held", 32'(pout_data_m), 32'hFF);
    check("bp still full", 32'(sin_ready_m), 32'd0);
    pout_ready = 1'b1;
    drive(1'b0, 1'b0);
    check("bp second valid",   32'(pout_valid_m),   32'd1);
    check("bp second data",    32'(pout_data_m),    32'h01);
    check("bp second lsb",     32'(pout_data_l),    32'h80);
    check("bp second nonzero", 32'(pout_nonzero_m), 32'd1);
    check("bp ready back",     32'(sin_ready_m),    32'd1);
    drive(1'b0, 1'b0);
    check("bp drained", 32'(pout_valid_m), 32'd0);

    // Continuous stream of three words
    stream = '{8'h3C, 8'hC3, 8'h81};
    pulses = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 7; i >= 0; i--) begin
        check("stream ready", 32'(sin_ready_m), 32'd1);
        drive(1'b1, stream[w][i]);
        if (pout_valid_m) pulses++;
      end
      check("stream word", 32'(pout_data_m), 32'(stream[w]));
    end
    check("stream pulses", 32'(pulses), 32'd3);
    drive(1'b0, 1'b0);

    // Reset mid-word
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    rst_n = 1'b0;
    drive(1'b1, 1'b1);
    check("midrst valid", 32'(pout_valid_m), 32'd0);
    check("midrst data",  32'(pout_data_m),  32'd0);
    check("midrst ready", 32'(sin_ready_m),  32'd0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'h3C;
      drive(1'b1, b[i]);
      if (pout_valid_m) pulses++;
    end
    check("midrst word",   32'(pout_data_m), 32'h3C);
    check("midrst pulses", 32'(pulses),      32'd1);
    drive(1'b0, 1'b0);

    // Reset while FULL
    pout_ready = 1'b0;
    send_byte(8'h55);
    send_byte(8'hAA);
    check("full before rst", 32'(sin_ready_m), 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    check("fullrst valid",   32'(pout_valid_m),   32'd0);
    check("fullrst data",    32'(pout_data_m),    32'd0);
    check("fullrst nonzero", 32'(pout_nonzero_m), 32'd0);
    rst_n      = 1'b1;
    pout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      check("fullrst discarded", 32'(pout_valid_m), 32'd0);
    end
    check("fullrst ready", 32'(sin_ready_m), 32'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
